// File: rtl/sweep_nco_controller.sv
// sweep_nco_controller
//   Stepped-frequency sweep generator driving a phase accumulator (NCO).
//   A sweep is launched from IDLE by start. The frequency control word (fcw)
//   is stepped by step_fcw every dwell period. The sweep runs single up,
//   single down or as a continuous triangle. abort or reset ends a sweep at
//   once.
//
//   Optional build macro: SWEEP_DITHER_EN adds a 16-bit LFSR whose low nibble
//   is added to the phase output only. The accumulator itself is untouched.
//
//   Ports
//     clk, rst_n       : clock (rising edge), async active-low reset
//     start, abort     : launch sweep (sampled in IDLE) / terminate sweep
//     start_fcw        : first fcw of the sweep
//     step_fcw         : fcw increment per step
//     num_steps        : steps per sweep leg (0 treated as 1)
//     dwell_cycles     : cycles per step (0 treated as 1)
//     mode             : 00 up, 01 down, 10 triangle, 11 same as 00
//     fcw, phase       : current fcw and accumulator phase
//     phase_valid,busy : high while running
//     step_idx         : current step index
//     step_strobe      : one-cycle pulse whenever fcw changes mid-sweep
//     done             : one-cycle pulse on normal completion
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | waiting for start; fcw/step_idx/phase hold last values
//   RUN   | accumulating phase and stepping fcw every dwell period
//   DONE  | single-cycle completion pulse, then back to IDLE
module sweep_nco_controller #(
  parameter int PHASE_W = 32,
  parameter int STEPS_W = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] start_fcw,
  input  logic [PHASE_W-1:0] step_fcw,
  input  logic [STEPS_W-1:0] num_steps,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [1:0]         mode,
  output logic [PHASE_W-1:0] fcw,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic [STEPS_W-1:0] step_idx,
  output logic               step_strobe,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;

  state_t state_q, state_d;

  logic [PHASE_W-1:0] fcw_q, fcw_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [STEPS_W-1:0] step_idx_q, step_idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               step_strobe_q, step_strobe_d;
  logic               dir_down_q, dir_down_d;

  // Configuration captured at start; zero counts are folded into "last"
  // values here so the run logic only ever compares against them.
  logic [PHASE_W-1:0] step_fcw_q, step_fcw_d;
  logic [STEPS_W-1:0] last_idx_q, last_idx_d;
  logic [DWELL_W-1:0] dwell_last_q, dwell_last_d;
  logic [1:0]         mode_q, mode_d;

  logic launch;
  logic step_end;
  logic last_step;

  assign launch    = (state_q == S_IDLE) && start && !abort;
  assign step_end  = (state_q == S_RUN) && (dwell_q == dwell_last_q);
  assign last_step = (step_idx_q == last_idx_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (launch) state_d = S_RUN;
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (step_end && (mode_q != MODE_TRI) && last_step) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state_q == S_RUN);
    phase_valid = (state_q == S_RUN);
    done        = (state_q == S_DONE);
    fcw         = fcw_q;
    step_idx    = step_idx_q;
    step_strobe = step_strobe_q;
  end

  // Datapath next-value logic
  always_comb begin
    fcw_d         = fcw_q;
    acc_d         = acc_q;
    step_idx_d    = step_idx_q;
    dwell_d       = dwell_q;
    step_strobe_d = 1'b0;
    dir_down_d    = dir_down_q;
    step_fcw_d    = step_fcw_q;
    last_idx_d    = last_idx_q;
    dwell_last_d  = dwell_last_q;
    mode_d        = mode_q;

    if (launch) begin
      fcw_d        = start_fcw;
      acc_d        = '0;
      step_idx_d   = '0;
      dwell_d      = '0;
      dir_down_d   = 1'b0;
      step_fcw_d   = step_fcw;
      last_idx_d   = (num_steps == '0) ? '0 : num_steps - STEPS_W'(1);
      dwell_last_d = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_W'(1);
      mode_d       = (mode == 2'b11) ? MODE_UP : mode;
    end else if (state_q == S_RUN) begin
      acc_d = acc_q + fcw_q;
      if (!abort) begin
        if (!step_end) begin
          dwell_d = dwell_q + DWELL_W'(1);
        end else begin
          dwell_d = '0;
          unique case (mode_q)
            MODE_TRI: begin
              // A one-step triangle has nowhere to go: fcw simply holds.
              if (last_idx_q != '0) begin
                if (!dir_down_q) begin
                  if (!last_step) begin
                    fcw_d      = fcw_q + step_fcw_q;
                    step_idx_d = step_idx_q + STEPS_W'(1);
                  end else begin
                    dir_down_d = 1'b1;
                    fcw_d      = fcw_q - step_fcw_q;
                    step_idx_d = step_idx_q - STEPS_W'(1);
                  end
                end else begin
                  if (step_idx_q != '0) begin
                    fcw_d      = fcw_q - step_fcw_q;
                    step_idx_d = step_idx_q - STEPS_W'(1);
                  end else begin
                    dir_down_d = 1'b0;
                    fcw_d      = fcw_q + step_fcw_q;
                    step_idx_d = step_idx_q + STEPS_W'(1);
                  end
                end
                step_strobe_d = 1'b1;
              end
            end
            MODE_DOWN: begin
              if (!last_step) begin
                fcw_d         = fcw_q - step_fcw_q;
                step_idx_d    = step_idx_q + STEPS_W'(1);
                step_strobe_d = 1'b1;
              end
            end
            default: begin
              if (!last_step) begin
                fcw_d         = fcw_q + step_fcw_q;
                step_idx_d    = step_idx_q + STEPS_W'(1);
                step_strobe_d = 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcw_q         <= '0;
      acc_q         <= '0;
      step_idx_q    <= '0;
      dwell_q       <= '0;
      step_strobe_q <= 1'b0;
      dir_down_q    <= 1'b0;
      step_fcw_q    <= '0;
      last_idx_q    <= '0;
      dwell_last_q  <= '0;
      mode_q        <= MODE_UP;
    end else begin
      fcw_q         <= fcw_d;
      acc_q         <= acc_d;
      step_idx_q    <= step_idx_d;
      dwell_q       <= dwell_d;
      step_strobe_q <= step_strobe_d;
      dir_down_q    <= dir_down_d;
      step_fcw_q    <= step_fcw_d;
      last_idx_q    <= last_idx_d;
      dwell_last_q  <= dwell_last_d;
      mode_q        <= mode_d;
    end
  end

`ifdef SWEEP_DITHER_EN
  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    lfsr_d = lfsr_q;
    if (launch) lfsr_d = LFSR_SEED;
    else if (state_q == S_RUN) lfsr_d = {lfsr_q[14:0], lfsr_fb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign phase = acc_q + PHASE_W'(lfsr_q[3:0]);
`else
  assign phase = acc_q;
`endif

endmodule

// File: tb/tb_sweep_nco_controller.sv
module tb_sweep_nco_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] start_fcw;
  logic [31:0] step_fcw;
  logic [7:0]  num_steps;
  logic [15:0] dwell_cycles;
  logic [1:0]  mode;
  logic [31:0] fcw;
  logic [31:0] phase;
  logic        phase_valid;
  logic [7:0]  step_idx;
  logic        step_strobe;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_acc;
  logic [15:0] m_lfsr;
  logic [31:0] ef;
  int          strobes;
  int          idx_tri;
  int          tri_tab[4] = '{0, 1, 2, 1};

  sweep_nco_controller #(
    .PHASE_W(32),
    .STEPS_W(8),
    .DWELL_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .start_fcw(start_fcw),
    .step_fcw(step_fcw),
    .num_steps(num_steps),
    .dwell_cycles(dwell_cycles),
    .mode(mode),
    .fcw(fcw),
    .phase(phase),
    .phase_valid(phase_valid),
    .step_idx(step_idx),
    .step_strobe(step_strobe),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_phase();
`ifdef SWEEP_DITHER_EN
    return m_acc + {28'd0, m_lfsr[3:0]};
`else
    return m_acc;
`endif
  endfunction

  // One RUN cycle of the reference model: accumulator and dither LFSR.
  task automatic model_cycle(input logic [31:0] cur_fcw);
    m_acc  = m_acc + cur_fcw;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic do_start(input logic [31:0] sf, input logic [31:0] st,
                          input logic [7:0] ns, input logic [15:0] dw,
                          input logic [1:0] md);
    start_fcw    = sf;
    step_fcw     = st;
    num_steps    = ns;
    dwell_cycles = dw;
    mode         = md;
    start        = 1'b1;
    tick();
    start  = 1'b0;
    m_acc  = 32'd0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_fcw"}, {32'd0, fcw}, 64'd0);
    chk({tag, "_phase"}, {32'd0, phase}, 64'd0);
    chk({tag, "_idx"}, {56'd0, step_idx}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_pv"}, {63'd0, phase_valid}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_strobe"}, {63'd0, step_strobe}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    start_fcw = '0; step_fcw = '0; num_steps = '0; dwell_cycles = '0; mode = '0;
    m_acc = '0; m_lfsr = 16'hACE1;
    #12;
`ifdef SWEEP_DITHER_EN
    // Dither adds the seed nibble (1) to the phase output even in reset.
    chk("rst_phase_dither", {32'd0, phase}, 64'd1);
`else
    chk("rst_phase", {32'd0, phase}, 64'd0);
`endif
    chk("rst_fcw", {32'd0, fcw}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_strobe", {63'd0, step_strobe}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Mode 00 reference sweep; config and start are disturbed mid-run.
    do_start(32'd89478485, 32'd9942053, 8'd10, 16'd4, 2'b00);
    strobes = 0;
    for (int c = 0; c < 40; c++) begin
      ef = 32'd89478485 + 32'(c / 4) * 32'd9942053;
      chk("m00_busy", {63'd0, busy}, 64'd1);
      chk("m00_pv", {63'd0, phase_valid}, 64'd1);
      chk("m00_fcw", {32'd0, fcw}, {32'd0, ef});
      chk("m00_idx", {56'd0, step_idx}, 64'(c / 4));
      chk("m00_strobe", {63'd0, step_strobe}, {63'd0, (c % 4 == 0) && (c > 0)});
      chk("m00_phase", {32'd0, phase}, {32'd0, exp_phase()});
      chk("m00_done", {63'd0, done}, 64'd0);
      if (step_strobe) strobes++;
      if (c == 2) begin
        start_fcw = 32'd7; step_fcw = 32'd1; num_steps = 8'd2;
        dwell_cycles = 16'd1; mode = 2'b01;
      end
      start = (c == 5);
      model_cycle(ef);
      tick();
    end
    chk("m00_done_pulse", {63'd0, done}, 64'd1);
    chk("m00_done_busy", {63'd0, busy}, 64'd0);
    chk("m00_final_fcw", {32'd0, fcw}, 64'd178956962);
    chk("m00_final_idx", {56'd0, step_idx}, 64'd9);
    chk("m00_strobes", 64'(strobes), 64'd9);
    tick();
    chk("m00_done_clear", {63'd0, done}, 64'd0);
    chk("m00_idle_busy", {63'd0, busy}, 64'd0);
    chk("m00_idle_phase", {32'd0, phase}, {32'd0, exp_phase()});

    // Mode 10 triangle; abort lands on a step-end cycle.
    do_start(32'd100, 32'd10, 8'd3, 16'd2, 2'b10);
    for (int c = 0; c < 22; c++) begin
      idx_tri = tri_tab[(c / 2) % 4];
      ef = 32'd100 + 32'(idx_tri) * 32'd10;
      chk("m10_fcw", {32'd0, fcw}, {32'd0, ef});
      chk("m10_idx", {56'd0, step_idx}, 64'(idx_tri));
      chk("m10_strobe", {63'd0, step_strobe}, {63'd0, (c % 2 == 0) && (c > 0)});
      chk("m10_done", {63'd0, done}, 64'd0);
      chk("m10_phase", {32'd0, phase}, {32'd0, exp_phase()});
      abort = (c == 21);
      model_cycle(ef);
      tick();
    end
    abort = 1'b0;
    chk("m10_abort_busy", {63'd0, busy}, 64'd0);
    chk("m10_abort_done", {63'd0, done}, 64'd0);
    chk("m10_abort_fcw", {32'd0, fcw}, 64'd120);
    chk("m10_abort_strobe", {63'd0, step_strobe}, 64'd0);
    tick();
    chk("idle_hold_phase", {32'd0, phase}, {32'd0, exp_phase()});
    chk("idle_hold_idx", {56'd0, step_idx}, 64'd2);
    chk("idle_hold_pv", {63'd0, phase_valid}, 64'd0);

    // start together with abort in IDLE stays in IDLE.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", {63'd0, busy}, 64'd0);
    chk("start_abort_fcw", {32'd0, fcw}, 64'd120);

    // Phase wrap, single step.
    do_start(32'h8000_0000, 32'd5, 8'd1, 16'd3, 2'b00);
    chk("wrap_ph0", {32'd0, phase}, {32'd0, exp_phase()});
    model_cycle(32'h8000_0000); tick();
    chk("wrap_ph1", {32'd0, phase}, {32'd0, exp_phase()});
    chk("wrap_ph1_raw", {32'd0, m_acc}, 64'h8000_0000);
    model_cycle(32'h8000_0000); tick();
    chk("wrap_ph2", {32'd0, phase}, {32'd0, exp_phase()});
    chk("wrap_strobe", {63'd0, step_strobe}, 64'd0);
    tick();
    chk("wrap_done", {63'd0, done}, 64'd1);

    // Zero configuration: one RUN cycle then done.
    tick();
    do_start(32'd50, 32'd5, 8'd0, 16'd0, 2'b00);
    chk("zero_busy", {63'd0, busy}, 64'd1);
    chk("zero_strobe0", {63'd0, step_strobe}, 64'd0);
    tick();
    chk("zero_done", {63'd0, done}, 64'd1);
    chk("zero_strobe1", {63'd0, step_strobe}, 64'd0);
    chk("zero_fcw", {32'd0, fcw}, 64'd50);
    tick();

    // Mode 01 single down.
    do_start(32'd1000, 32'd100, 8'd3, 16'd1, 2'b01);
    for (int c = 0; c < 3; c++) begin
      chk("m01_fcw", {32'd0, fcw}, 64'(1000 - 100 * c));
      chk("m01_idx", {56'd0, step_idx}, 64'(c));
      tick();
    end
    chk("m01_done", {63'd0, done}, 64'd1);
    tick();

    // Mode 11 behaves as single up.
    do_start(32'd5, 32'd3, 8'd2, 16'd1, 2'b11);
    chk("m11_fcw0", {32'd0, fcw}, 64'd5);
    tick();
    chk("m11_fcw1", {32'd0, fcw}, 64'd8);
    chk("m11_strobe", {63'd0, step_strobe}, 64'd1);
    tick();
    chk("m11_done", {63'd0, done}, 64'd1);
    tick();

    // Triangle with one step never changes fcw.
    do_start(32'd77, 32'd9, 8'd1, 16'd1, 2'b10);
    for (int c = 0; c < 6; c++) begin
      chk("tri1_fcw", {32'd0, fcw}, 64'd77);
      chk("tri1_strobe", {63'd0, step_strobe}, 64'd0);
      chk("tri1_busy", {63'd0, busy}, 64'd1);
      tick();
    end
    abort = 1'b1; tick(); abort = 1'b0;
    chk("tri1_abort_busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset between edges mid-sweep.
    do_start(32'd1000, 32'd10, 8'd10, 16'd2, 2'b00);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_idle_zero("arst");
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("arst_post_done", {63'd0, done}, 64'd0);
      chk("arst_post_busy", {63'd0, busy}, 64'd0);
    end
    do_start(32'd20, 32'd4, 8'd2, 16'd1, 2'b00);
    chk("arst_new_fcw0", {32'd0, fcw}, 64'd20);
    tick();
    chk("arst_new_fcw1", {32'd0, fcw}, 64'd24);
    tick();
    chk("arst_new_done", {63'd0, done}, 64'd1);
    tick();

    // Dither: with start_fcw 0 the phase output is only the LFSR nibble.
    do_start(32'd0, 32'd0, 8'd1, 16'd4, 2'b00);
`ifdef SWEEP_DITHER_EN
    chk("dither_first", {32'd0, phase}, 64'd1);
`else
    chk("dither_first", {32'd0, phase}, 64'd0);
`endif
    for (int c = 0; c < 4; c++) begin
      chk("dither_phase", {32'd0, phase}, {32'd0, exp_phase()});
      model_cycle(32'd0);
      tick();
    end
    chk("dither_done", {63'd0, done}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
